// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, req/ready fetch handshake, IF/ID register,
// one-entry skid buffer for decode stalls and branch flush with response drop.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr,
  output logic [5:0]  OpCode,
  output logic [31:0] PcPlus4,
  output logic        Valid
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic        started_q, started_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic        buf_full_q, buf_full_d;

  logic        hs;
  logic [31:0] pc_next;

  // started_q keeps the request low during reset; DROP presents the
  // pre-branch address so an outstanding request stays stable.
  assign IMemReq  = started_q && (state_q != S_HOLD);
  assign IMemAddr = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign hs       = IMemReq && IMemReady;
  assign pc_next  = pc_q + 32'd4;

  assign Instr   = instr_q;
  assign OpCode  = instr_q[31:26];
  assign PcPlus4 = pc4_q;
  assign Valid   = valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    started_d   = 1'b1;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    buf_full_d  = buf_full_q;

    if (BranchTaken) begin
      pc_d       = {BranchTarget[31:2], 2'b00};
      valid_d    = 1'b0;
      buf_full_d = 1'b0;
      if (IMemReq && !IMemReady) begin
        state_d     = S_DROP;
        drop_addr_d = IMemAddr;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (hs) begin
            pc_d = pc_next;
            if (!Stall) begin
              instr_d = IMemData;
              pc4_d   = pc_next;
              valid_d = 1'b1;
            end else begin
              buf_instr_d = IMemData;
              buf_pc4_d   = pc_next;
              buf_full_d  = 1'b1;
              state_d     = S_HOLD;
            end
          end else if (!Stall) begin
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!Stall && buf_full_q) begin
            instr_d    = buf_instr_q;
            pc4_d      = buf_pc4_q;
            valid_d    = 1'b1;
            buf_full_d = 1'b0;
            state_d    = S_FETCH;
          end
        end
        S_DROP: begin
          if (hs) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      started_q   <= 1'b0;
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
      buf_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      started_q   <= started_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      buf_full_q  <= buf_full_d;
    end
  end

endmodule
